ex: RTL and testbench

- Execute stage. Sits directly downstream of id and consumes its decoded instruction and operands.
- Drives the write-back port of regs (reg_wdata/we/waddr) and the jump inputs of pc_reg.
- Drives the pipeline hold flag used by pc_reg and if_id.
- Single-cycle ALU, branch and jump ops are combinational; DIV/DIVU/REM/REMU run on a sequential radix-2 divider that stalls the front end.

---
 rtl/ex.sv | 262 ++++++++++++++++++++++++++
 tb/tb_ex.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex.sv
// Execute stage: combinational ALU/branch/jump/multiply plus a sequential
// restoring divider that holds the front end while it iterates.
module ex #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic        reg_we_i,
  input  logic [4:0]  reg_waddr_i,
  output logic [31:0] reg_wdata_o,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic [2:0]  hold_flag_o
);

  localparam int unsigned CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        dvd_q, dvd_d;
  logic [31:0]        dvs_q, dvs_d;
  logic [31:0]        rem_q, rem_d;
  logic               rem_sel_q, rem_sel_d;
  logic [4:0]         rd_q, rd_d;
  logic               we_q, we_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               done_prev_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_b, imm_u, imm_j;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];
  assign imm_i  = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_b  = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u  = {inst_i[31:12], 12'b0};
  assign imm_j  = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JLR = 7'b1100111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  logic is_div, div_start, div_signed, div_ovf, div_zero, a_neg, b_neg;

  assign is_div     = (opcode == OP_REG) && (funct7 == 7'b0000001) && funct3[2];
  // The finishing divide is still presented in the cycle after DONE; ignore it.
  assign div_start  = (state_q == S_IDLE) && is_div && !done_prev_q;
  assign div_signed = !funct3[0];
  assign div_zero   = (op2_i == '0);
  assign div_ovf    = div_signed && (op1_i == 32'h8000_0000) && (op2_i == '1);
  assign a_neg      = div_signed && op1_i[31];
  assign b_neg      = div_signed && op2_i[31];

  logic [32:0] step_acc;
  logic        step_ge;
  logic [31:0] step_rem;
  logic [31:0] div_res;

  assign step_acc = {rem_q, dvd_q[31]};
  assign step_ge  = (step_acc >= {1'b0, dvs_q});
  assign step_rem = step_ge ? 32'(step_acc - {1'b0, dvs_q}) : step_acc[31:0];
  assign div_res  = rem_sel_q ? (rneg_q ? -rem_q : rem_q)
                              : (qneg_q ? -dvd_q : dvd_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      rem_sel_q   <= 1'b0;
      rd_q        <= '0;
      we_q        <= 1'b0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      rem_sel_q   <= rem_sel_d;
      rd_q        <= rd_d;
      we_q        <= we_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      done_prev_q <= (state_q == S_DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (div_start) state_d = (div_zero || div_ovf) ? S_DONE : S_BUSY;
      S_BUSY:  if (cnt_q == CNT_W'(DIV_CYCLES - 1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Quotient shifts into dvd_q as dividend bits shift out.
  always_comb begin
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    rem_sel_d = rem_sel_q;
    rd_d      = rd_q;
    we_d      = we_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    if (div_start) begin
      rem_sel_d = funct3[1];
      rd_d      = reg_waddr_i;
      we_d      = reg_we_i;
      cnt_d     = '0;
      if (div_zero) begin
        dvd_d  = '1;
        rem_d  = op1_i;
        qneg_d = 1'b0;
        rneg_d = 1'b0;
      end else if (div_ovf) begin
        dvd_d  = 32'h8000_0000;
        rem_d  = '0;
        qneg_d = 1'b0;
        rneg_d = 1'b0;
      end else begin
        dvd_d  = a_neg ? -op1_i : op1_i;
        dvs_d  = b_neg ? -op2_i : op2_i;
        rem_d  = '0;
        qneg_d = a_neg ^ b_neg;
        rneg_d = a_neg;
      end
    end else if (state_q == S_BUSY) begin
      dvd_d = {dvd_q[30:0], step_ge};
      rem_d = step_rem;
      cnt_d = cnt_q + 1'b1;
    end
  end

  logic [31:0] alu_src2, alu_res, mul_res, pc_plus4;
  logic [4:0]  shamt;
  logic [63:0] mul_a, mul_b, mul_p;
  logic        br_taken;

  assign alu_src2 = (opcode == OP_REG) ? op2_i : imm_i;
  assign shamt    = alu_src2[4:0];
  assign pc_plus4 = inst_addr_i + 32'd4;

  always_comb begin
    alu_res = '0;
    case (funct3)
      3'b000: alu_res = ((opcode == OP_REG) && inst_i[30]) ? op1_i - alu_src2 : op1_i + alu_src2;
      3'b001: alu_res = op1_i << shamt;
      3'b010: alu_res = {31'b0, $signed(op1_i) < $signed(alu_src2)};
      3'b011: alu_res = {31'b0, op1_i < alu_src2};
      3'b100: alu_res = op1_i ^ alu_src2;
      3'b101: alu_res = inst_i[30] ? 32'($signed(op1_i) >>> shamt) : op1_i >> shamt;
      3'b110: alu_res = op1_i | alu_src2;
      default: alu_res = op1_i & alu_src2;
    endcase
  end

  // MULH sign-extends both operands, MULHSU only op1, MULHU neither.
  assign mul_a   = {{32{op1_i[31] & (funct3 == 3'b001 || funct3 == 3'b010)}}, op1_i};
  assign mul_b   = {{32{op2_i[31] & (funct3 == 3'b001)}}, op2_i};
  assign mul_p   = mul_a * mul_b;
  assign mul_res = (funct3 == 3'b000) ? mul_p[31:0] : mul_p[63:32];

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (op1_i == op2_i);
      3'b001:  br_taken = (op1_i != op2_i);
      3'b100:  br_taken = ($signed(op1_i) <  $signed(op2_i));
      3'b101:  br_taken = ($signed(op1_i) >= $signed(op2_i));
      3'b110:  br_taken = (op1_i <  op2_i);
      3'b111:  br_taken = (op1_i >= op2_i);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    reg_wdata_o = '0;
    reg_we_o    = 1'b0;
    reg_waddr_o = '0;
    jump_flag_o = 1'b0;
    jump_addr_o = '0;
    hold_flag_o = 3'd0;
    if (rst) begin
      case (state_q)
        S_BUSY: hold_flag_o = 3'd3;
        S_DONE: begin
          reg_we_o    = we_q;
          reg_waddr_o = rd_q;
          reg_wdata_o = div_res;
        end
        default: begin
          if (div_start) begin
            hold_flag_o = 3'd3;
          end else if (!is_div) begin
            reg_waddr_o = reg_waddr_i;
            case (opcode)
              OP_IMM: begin
                reg_we_o    = reg_we_i;
                reg_wdata_o = alu_res;
              end
              OP_REG: begin
                reg_we_o    = reg_we_i;
                reg_wdata_o = (funct7 == 7'b0000001) ? mul_res : alu_res;
              end
              OP_LUI: begin
                reg_we_o    = reg_we_i;
                reg_wdata_o = imm_u;
              end
              OP_AUI: begin
                reg_we_o    = reg_we_i;
                reg_wdata_o = inst_addr_i + imm_u;
              end
              OP_JAL: begin
                reg_we_o    = reg_we_i;
                reg_wdata_o = pc_plus4;
                jump_flag_o = 1'b1;
                jump_addr_o = inst_addr_i + imm_j;
              end
              OP_JLR: begin
                reg_we_o    = reg_we_i;
                reg_wdata_o = pc_plus4;
                jump_flag_o = 1'b1;
                jump_addr_o = (op1_i + imm_i) & ~32'd1;
              end
              OP_BR: begin
                jump_flag_o = br_taken;
                jump_addr_o = br_taken ? inst_addr_i + imm_b : '0;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex.sv
// Scoreboard bench for ex: expected outputs are queued per cycle as stimulus
// is applied and compared on the falling edge of that cycle.
module tb_ex;

  localparam int unsigned DIV_CYCLES = 32;

  logic        clk;
  logic        rst;
  logic [31:0] inst, pc, a, b;
  logic        we_i;
  logic [4:0]  rd;
  logic [31:0] reg_wdata_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic [2:0]  hold_flag_o;

  ex #(.DIV_CYCLES(DIV_CYCLES)) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_i      (inst),
    .inst_addr_i (pc),
    .op1_i       (a),
    .op2_i       (b),
    .reg_we_i    (we_i),
    .reg_waddr_i (rd),
    .reg_wdata_o (reg_wdata_o),
    .reg_we_o    (reg_we_o),
    .reg_waddr_o (reg_waddr_o),
    .jump_flag_o (jump_flag_o),
    .jump_addr_o (jump_addr_o),
    .hold_flag_o (hold_flag_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned due;
    string       tag;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        jf;
    logic [31:0] ja;
    logic [2:0]  hold;
    bit          cwd;
    bit          cja;
  } exp_t;

  exp_t sb[$];
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  exp_t cur;
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].due <= cyc) begin
      cur = sb.pop_front();
      if (cur.due != cyc) begin
        check({cur.tag, "_due"}, cyc, cur.due);
      end else begin
        check({cur.tag, "_hold"}, {29'b0, hold_flag_o}, {29'b0, cur.hold});
        check({cur.tag, "_we"}, {31'b0, reg_we_o}, {31'b0, cur.we});
        check({cur.tag, "_jf"}, {31'b0, jump_flag_o}, {31'b0, cur.jf});
        if (cur.cja) check({cur.tag, "_ja"}, jump_addr_o, cur.ja);
        if (cur.cwd) begin
          check({cur.tag, "_wa"}, {27'b0, reg_waddr_o}, {27'b0, cur.wa});
          check({cur.tag, "_wd"}, reg_wdata_o, cur.wd);
        end
      end
    end
  end

  task automatic expect_out(input string tag, input logic we, input logic [4:0] wa,
                            input logic [31:0] wd, input logic jf, input logic [31:0] ja,
                            input logic [2:0] hold, input bit cwd, input bit cja);
    exp_t e;
    e.due = cyc; e.tag = tag; e.we = we; e.wa = wa; e.wd = wd;
    e.jf = jf; e.ja = ja; e.hold = hold; e.cwd = cwd; e.cja = cja;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3,
                                        input logic [4:0] rdi, input logic [6:0] op);
    return {imm, 5'd0, f3, rdi, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rdi);
    return {f7, 5'd0, 5'd0, f3, rdi, 7'h33};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd0, 5'd0, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rdi);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rdi, 7'h6f};
  endfunction

  function automatic logic [31:0] div_ref(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    logic sgn, rem;
    sgn = !f3[0];
    rem = f3[1];
    if (y == 32'd0) return rem ? x : 32'hFFFF_FFFF;
    if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
    if (sgn) return rem ? 32'($signed(x) % $signed(y)) : 32'($signed(x) / $signed(y));
    return rem ? x % y : x / y;
  endfunction

  task automatic set_in(input logic [31:0] i, input logic [31:0] p, input logic [31:0] x,
                        input logic [31:0] y, input logic w, input logic [4:0] r);
    inst = i; pc = p; a = x; b = y; we_i = w; rd = r;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic [31:0] x,
                       input logic [31:0] y, input logic w, input logic [4:0] r);
    @(posedge clk); #1;
    set_in(i, p, x, y, w, r);
  endtask

  task automatic run_op(input string tag, input logic [31:0] i, input logic [31:0] p,
                        input logic [31:0] x, input logic [31:0] y, input logic [4:0] r,
                        input logic ewe, input logic [31:0] ewd, input logic ejf,
                        input logic [31:0] eja, input bit cwd, input bit cja);
    drive(i, p, x, y, 1'b1, r);
    expect_out(tag, ewe, r, ewd, ejf, eja, 3'd0, cwd, cja);
  endtask

  task automatic do_div(input string tag, input logic [2:0] f3, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] r, input bit disturb);
    int unsigned lat;
    logic [31:0] di;
    di  = enc_r(7'h01, f3, r);
    lat = (y == 32'd0 || (!f3[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) ? 1 : DIV_CYCLES + 1;
    drive(di, 32'h200, x, y, 1'b1, r);
    expect_out({tag, "_issue"}, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 3'd3, 1'b0, 1'b0);
    for (int unsigned k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      if (disturb && k == 5) begin
        set_in(enc_j(21'h40, 5'd9), 32'h300, 32'd0, 32'd0, 1'b1, 5'd9);
        expect_out({tag, "_busy_ign"}, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 3'd3, 1'b0, 1'b0);
      end else if (disturb && k == 6) begin
        set_in(di, 32'h200, x, y, 1'b1, r);
      end
      if (lat > 1 && k == lat - 1)
        expect_out({tag, "_last_busy"}, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 3'd3, 1'b0, 1'b0);
      if (k == lat)
        expect_out({tag, "_res"}, 1'b1, r, div_ref(f3, x, y), 1'b0, 32'd0, 3'd0, 1'b1, 1'b0);
    end
    @(posedge clk); #1;
    expect_out({tag, "_norestart"}, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 3'd0, 1'b0, 1'b0);
    drive(enc_i(12'd0, 3'd0, 5'd0, 7'h13), 32'h204, 32'd0, 32'd0, 1'b0, 5'd0);
    expect_out({tag, "_idle"}, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 3'd0, 1'b0, 1'b0);
  endtask

  logic [31:0] addi5;

  initial begin
    addi5 = enc_i(12'd5, 3'd0, 5'd1, 7'h13);
    rst = 1'b0;
    set_in(addi5, 32'd0, 32'd0, 32'd0, 1'b1, 5'd1);
    @(posedge clk); #1;
    expect_out("reset", 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 3'd0, 1'b1, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    expect_out("addi", 1'b1, 5'd1, 32'd5, 1'b0, 32'd0, 3'd0, 1'b1, 1'b0);

    run_op("sub",    enc_r(7'h20, 3'd0, 5'd2), 0, 32'd5, 32'd7, 5'd2, 1, 32'hFFFF_FFFE, 0, 0, 1, 0);
    run_op("sra",    enc_r(7'h20, 3'd5, 5'd3), 0, 32'h8000_0000, 32'h24, 5'd3, 1, 32'hF800_0000, 0, 0, 1, 0);
    run_op("srai",   enc_i(12'h404, 3'd5, 5'd3, 7'h13), 0, 32'h8000_0010, 0, 5'd3, 1, 32'hF800_0001, 0, 0, 1, 0);
    run_op("sltu",   enc_r(7'h00, 3'd3, 5'd4), 0, 32'd1, 32'hFFFF_FFFF, 5'd4, 1, 32'd1, 0, 0, 1, 0);
    run_op("slt",    enc_r(7'h00, 3'd2, 5'd4), 0, 32'd1, 32'hFFFF_FFFF, 5'd4, 1, 32'd0, 0, 0, 1, 0);
    run_op("mul",    enc_r(7'h01, 3'd0, 5'd5), 0, 32'd7, 32'd6, 5'd5, 1, 32'd42, 0, 0, 1, 0);
    run_op("mulh",   enc_r(7'h01, 3'd1, 5'd5), 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1, 32'd0, 0, 0, 1, 0);
    run_op("mulhsu", enc_r(7'h01, 3'd2, 5'd5), 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1, 32'hFFFF_FFFF, 0, 0, 1, 0);
    run_op("mulhu",  enc_r(7'h01, 3'd3, 5'd5), 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1, 32'hFFFF_FFFE, 0, 0, 1, 0);
    run_op("lui",    {20'h12345, 5'd6, 7'h37}, 0, 0, 0, 5'd6, 1, 32'h1234_5000, 0, 0, 1, 0);
    run_op("auipc",  {20'h00001, 5'd7, 7'h17}, 32'h100, 0, 0, 5'd7, 1, 32'h0000_1100, 0, 0, 1, 0);
    run_op("jal",    enc_j(21'h100, 5'd1), 32'h20, 0, 0, 5'd1, 1, 32'h24, 1, 32'h120, 1, 1);
    run_op("jalr",   enc_i(12'd0, 3'd0, 5'd1, 7'h67), 32'h40, 32'h103, 0, 5'd1, 1, 32'h44, 1, 32'h102, 1, 1);
    run_op("bne_t",  enc_b(13'h1FF8, 3'd1), 32'h10, 32'd1, 32'd2, 5'd0, 0, 0, 1, 32'h8, 0, 1);
    run_op("bne_n",  enc_b(13'h1FF8, 3'd1), 32'h10, 32'd3, 32'd3, 5'd0, 0, 0, 0, 0, 0, 0);
    run_op("beq_t",  enc_b(13'h0020, 3'd0), 32'h10, 32'd3, 32'd3, 5'd0, 0, 0, 1, 32'h30, 0, 1);
    run_op("blt_t",  enc_b(13'h0020, 3'd4), 32'h10, 32'hFFFF_FFFF, 32'd1, 5'd0, 0, 0, 1, 32'h30, 0, 1);
    run_op("bltu_n", enc_b(13'h0020, 3'd6), 32'h10, 32'hFFFF_FFFF, 32'd1, 5'd0, 0, 0, 0, 0, 0, 0);
    run_op("bgeu_t", enc_b(13'h0020, 3'd7), 32'h10, 32'hFFFF_FFFF, 32'd1, 5'd0, 0, 0, 1, 32'h30, 0, 1);
    run_op("fence",  32'h0000_000F, 0, 32'd1, 32'd1, 5'd8, 0, 0, 0, 0, 0, 0);

    do_div("div_neg",  3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b0);
    do_div("rem_neg",  3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11, 1'b0);
    do_div("rem_sgn",  3'd6, 32'd7, 32'hFFFF_FFFD, 5'd11, 1'b0);
    do_div("divu_z",   3'd5, 32'h1234, 32'd0, 5'd12, 1'b0);
    do_div("remu_z",   3'd7, 32'h1234, 32'd0, 5'd13, 1'b0);
    do_div("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b0);
    do_div("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b0);
    do_div("divu_big", 3'd5, 32'hFFFF_FFFF, 32'd3, 5'd15, 1'b0);
    for (int i = 0; i < 3; i++)
      do_div("div_rnd", 3'(4 + (i % 4)), $urandom, $urandom_range(32'h00FF_FFFF, 1), 5'd16, 1'b0);

    drive(enc_r(7'h01, 3'd4, 5'd3), 32'h200, 32'hFFFF_FFF9, 32'd2, 1'b1, 5'd3);
    expect_out("abort_issue", 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 3'd3, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    expect_out("abort_busy", 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 3'd3, 1'b0, 1'b0);
    @(posedge clk); #1;
    #2 rst = 1'b0;
    expect_out("abort_rst", 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 3'd0, 1'b1, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    set_in(enc_i(12'd0, 3'd0, 5'd0, 7'h13), 32'h204, 32'd0, 32'd0, 1'b0, 5'd0);
    expect_out("abort_idle", 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 3'd0, 1'b0, 1'b0);
    do_div("div_100_7", 3'd4, 32'd100, 32'd7, 5'd17, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    if (sb.size() != 0) check("sb_drain", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
